// File: rtl/huff_pkg.sv
// Shared defaults and FSM encoding for the canonical Huffman decode path.
package huff_pkg;

  localparam int SYM_W_DEF   = 8;
  localparam int MAX_LEN_DEF = 16;
  localparam int LEN_W_DEF   = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

endpackage

// File: rtl/huff_sym_mem.sv
// Canonical-order symbol table: synchronous write, combinational read, contents not reset.
module huff_sym_mem #(
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [SYM_W-1:0] waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [SYM_W-1:0] raddr,
  output logic [SYM_W-1:0] rdata
);

  logic [SYM_W-1:0] mem_q [0:(1<<SYM_W)-1];

  // Table write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/huff_canon_decoder.sv
// Bit-serial canonical Huffman decoder: load counts and symbols, validate the
// length histogram, then decode one MSB-first bit per cycle.
module huff_canon_decoder
  import huff_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cnt_we,
  input  logic [LEN_W-1:0] cnt_len,
  input  logic [SYM_W:0]   cnt_val,
  input  logic             sym_we,
  input  logic [SYM_W-1:0] sym_addr,
  input  logic [SYM_W-1:0] sym_val,
  input  logic             cfg_done,
  output logic             tbl_ready,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym_data,
  output logic [LEN_W-1:0] sym_len,
  input  logic             sym_ready,
  output logic             err
);

  localparam int CW = MAX_LEN + 1;
  localparam int LW = MAX_LEN + 2;
  localparam int AW = SYM_W + 1;

  logic [2:0]       state_q, state_d;
  logic [SYM_W:0]   cnt_q [1:MAX_LEN];
  logic [LW-1:0]    left_q, left_d;
  logic [LEN_W-1:0] chk_len_q, chk_len_d;
  logic             nz_q, nz_d;
  logic [CW-1:0]    code_q, code_d, first_q, first_d;
  logic [AW-1:0]    index_q, index_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0] sym_data_q, sym_data_d;
  logic [LEN_W-1:0] sym_len_q, sym_len_d;
  logic             err_q, err_d;
  logic             tbl_ready_q, tbl_ready_d;

  logic [LEN_W-1:0] sel_len_s;
  logic [SYM_W:0]   cur_cnt_s;
  logic [LW-1:0]    left_n_s;
  logic [CW-1:0]    code_c_s, diff_s;
  logic             match_s, accept_s, any_nz_s;
  logic [SYM_W-1:0] mem_addr_s, mem_rdata_s;
  logic             mem_we_s, cnt_wr_s;

  assign bit_ready = (state_q == ST_DECODE) & (~sym_valid_q | sym_ready);
  assign accept_s  = bit_valid & bit_ready;
  assign mem_we_s  = sym_we & (state_q == ST_LOAD) & ~cfg_start;
  assign cnt_wr_s  = cnt_we & (state_q == ST_LOAD);

  // One count mux serves both the histogram check and the decode walk
  assign sel_len_s = (state_q == ST_CHECK) ? chk_len_q : len_q;
  always_comb begin
    cur_cnt_s = '0;
    for (int l = 1; l <= MAX_LEN; l++) begin
      cur_cnt_s = (sel_len_s == LEN_W'(l)) ? cnt_q[l] : cur_cnt_s;
    end
  end

  assign left_n_s   = (left_q << 1) - LW'(cur_cnt_s);
  assign any_nz_s   = nz_q | (cur_cnt_s != '0);
  assign code_c_s   = code_q | CW'(bit_data);
  assign diff_s     = code_c_s - first_q;
  assign match_s    = diff_s < CW'(cur_cnt_s);
  assign mem_addr_s = SYM_W'(index_q + AW'(diff_s));

  huff_sym_mem #(.SYM_W(SYM_W)) u_sym_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (sym_addr),
    .wdata (sym_val),
    .raddr (mem_addr_s),
    .rdata (mem_rdata_s)
  );

  // Next-state logic for FSM, histogram check and decode walk
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    chk_len_d   = chk_len_q;
    nz_d        = nz_q;
    code_d      = code_q;
    first_d     = first_q;
    index_d     = index_q;
    len_d       = len_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    sym_len_d   = sym_len_q;
    err_d       = err_q;
    tbl_ready_d = tbl_ready_q;
    if (cfg_start) begin
      state_d     = ST_LOAD;
      err_d       = 1'b0;
      tbl_ready_d = 1'b0;
      sym_valid_d = 1'b0;
      code_d      = '0;
      first_d     = '0;
      index_d     = '0;
      len_d       = LEN_W'(1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          if (cfg_done) begin
            state_d   = ST_CHECK;
            left_d    = LW'(1);
            chk_len_d = LEN_W'(1);
            nz_d      = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_CHECK: begin
          left_d = left_n_s;
          nz_d   = any_nz_s;
          // Sign bit set means more codes than the code space at this length
          if (left_n_s[LW-1]) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else if (chk_len_q == LEN_W'(MAX_LEN)) begin
            if (any_nz_s) begin
              state_d     = ST_DECODE;
              tbl_ready_d = 1'b1;
            end else begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end
          end else begin
            chk_len_d = chk_len_q + LEN_W'(1);
          end
        end
        ST_DECODE: begin
          if (sym_valid_q && sym_ready) begin
            sym_valid_d = 1'b0;
          end else begin
            sym_valid_d = sym_valid_q;
          end
          if (accept_s) begin
            if (match_s) begin
              sym_valid_d = 1'b1;
              sym_data_d  = mem_rdata_s;
              sym_len_d   = len_q;
              code_d      = '0;
              first_d     = '0;
              index_d     = '0;
              len_d       = LEN_W'(1);
            end else if (len_q == LEN_W'(MAX_LEN)) begin
              state_d     = ST_ERR;
              err_d       = 1'b1;
              tbl_ready_d = 1'b0;
              sym_valid_d = 1'b0;
            end else begin
              index_d = index_q + AW'(cur_cnt_s);
              first_d = (first_q + CW'(cur_cnt_s)) << 1;
              code_d  = code_c_s << 1;
              len_d   = len_q + LEN_W'(1);
            end
          end else begin
            code_d = code_q;
          end
        end
        ST_ERR: begin
          sym_valid_d = 1'b0;
          tbl_ready_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Per-length code counts, cleared on every reload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 1; l <= MAX_LEN; l++) cnt_q[l] <= '0;
    end else if (cfg_start) begin
      for (int l = 1; l <= MAX_LEN; l++) cnt_q[l] <= '0;
    end else if (cnt_wr_s) begin
      for (int l = 1; l <= MAX_LEN; l++) begin
        if (cnt_len == LEN_W'(l)) cnt_q[l] <= cnt_val;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      left_q      <= '0;
      chk_len_q   <= '0;
      nz_q        <= 1'b0;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= LEN_W'(1);
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_len_q   <= '0;
      err_q       <= 1'b0;
      tbl_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      chk_len_q   <= chk_len_d;
      nz_q        <= nz_d;
      code_q      <= code_d;
      first_q     <= first_d;
      index_q     <= index_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      sym_len_q   <= sym_len_d;
      err_q       <= err_d;
      tbl_ready_q <= tbl_ready_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_len   = sym_len_q;
  assign err       = err_q;
  assign tbl_ready = tbl_ready_q;

endmodule

// File: tb/tb_huff_canon_decoder.sv
// Scoreboard bench for huff_canon_decoder using the 4-symbol table 41:0, 42:10, 43:110, 44:111.
module tb_huff_canon_decoder;

  logic       clk, rst_n, cfg_start, cnt_we, sym_we, cfg_done;
  logic [4:0] cnt_len;
  logic [8:0] cnt_val;
  logic [7:0] sym_addr, sym_val;
  logic       tbl_ready, bit_valid, bit_data, bit_ready, sym_valid, sym_ready, err;
  logic [7:0] sym_data;
  logic [4:0] sym_len;

  typedef struct {
    logic [7:0] s;
    logic [4:0] l;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  huff_canon_decoder dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cnt_we(cnt_we),
    .cnt_len(cnt_len), .cnt_val(cnt_val), .sym_we(sym_we), .sym_addr(sym_addr),
    .sym_val(sym_val), .cfg_done(cfg_done), .tbl_ready(tbl_ready),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_len(sym_len),
    .sym_ready(sym_ready), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_table(input int c1, input int c2, input int c3);
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    cnt_we = 1'b1; cnt_len = 5'd1; cnt_val = 9'(c1);
    @(negedge clk); cnt_len = 5'd2; cnt_val = 9'(c2);
    @(negedge clk); cnt_len = 5'd3; cnt_val = 9'(c3);
    @(negedge clk); cnt_we = 1'b0; sym_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sym_addr = 8'(i);
      sym_val  = 8'h41 + 8'(i);
      cfg_done = (i == 3);
      @(negedge clk);
    end
    sym_we = 1'b0; cfg_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (tbl_ready || err) break;
    end
  endtask

  task automatic run_stream(input logic [63:0] bits, input int n, input int stall_after,
                            input int stall_len, input int budget);
    int idx = 0, cyc = 0, nsym = 0, stall = 0;
    exp_t e;
    while ((idx < n || sym_valid || sb.size() > 0) && cyc < budget) begin
      @(negedge clk);
      sym_ready = (stall == 0);
      bit_valid = (idx < n);
      bit_data  = (idx < n) ? bits[n-1-idx] : 1'b0;
      #1;
      if (sym_valid && sym_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_sym: got %h/%0d, expected none", sym_data, sym_len);
        end else begin
          e = sb.pop_front();
          if (sym_data !== e.s || sym_len !== e.l) begin
            failures++;
            $display("FAIL sym_out: got %h/%0d, expected %h/%0d", sym_data, sym_len, e.s, e.l);
          end
        end
        nsym++;
        if (nsym == stall_after) stall = stall_len;
      end else if (stall > 0) begin
        if (sym_valid) begin
          checks++;
          if (bit_ready !== 1'b0 || (sb.size() > 0 && sym_data !== sb[0].s)) begin
            failures++;
            $display("FAIL stall_hold: bit_ready=%b sym_data=%h, expected bit_ready=0 sym_data=%h",
                     bit_ready, sym_data, (sb.size() > 0) ? sb[0].s : 8'h00);
          end
        end
        stall--;
      end
      if (bit_valid && bit_ready) idx++;
      cyc++;
    end
    if (sb.size() > 0 || idx < n) begin
      checks++; failures++;
      $display("FAIL stream_timeout: %0d symbols pending, %0d of %0d bits sent", sb.size(), idx, n);
      sb.delete();
    end
    @(negedge clk);
    bit_valid = 1'b0; sym_ready = 1'b1;
  endtask

  task automatic push(input logic [7:0] s, input logic [4:0] l);
    exp_t e;
    e.s = s; e.l = l;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({tbl_ready, bit_ready, sym_valid, sym_data, sym_len, err} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {tbl_ready, bit_ready, sym_valid, sym_data, sym_len, err});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load_table(1, 1, 2);
    checks++;
    if (tbl_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_ready: tbl_ready=%b err=%b, expected 1/0", tbl_ready, err);
    end
    push(8'h41, 5'd1); push(8'h42, 5'd2); push(8'h43, 5'd3); push(8'h44, 5'd3);
    run_stream(64'b010110111, 9, 0, 0, 100);
  endtask

  task automatic test_backpressure();
    push(8'h41, 5'd1); push(8'h42, 5'd2); push(8'h43, 5'd3); push(8'h44, 5'd3);
    run_stream(64'b010110111, 9, 1, 5, 100);
  endtask

  task automatic test_random_stream();
    logic [3:0] codes [4] = '{4'b0000, 4'b0010, 4'b0110, 4'b0111};
    int lens [4] = '{1, 2, 3, 3};
    for (int r = 0; r < 3; r++) begin
      logic [63:0] bits = '0;
      int n = 0;
      for (int j = 0; j < 12; j++) begin
        int k = $urandom_range(0, 3);
        bits = (bits << lens[k]) | 64'(codes[k]);
        n += lens[k];
        push(8'h41 + 8'(k), 5'(lens[k]));
      end
      run_stream(bits, n, r + 1, 2 * r + 1, 300);
    end
  endtask

  task automatic test_oversubscribed();
    load_table(3, 0, 0);
    checks++;
    if (err !== 1'b1 || tbl_ready !== 1'b0 || bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL oversub: err=%b tbl_ready=%b bit_ready=%b, expected 1/0/0", err, tbl_ready, bit_ready);
    end
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0; #1;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL oversub_clear: err=%b, expected 0", err);
    end
  endtask

  task automatic test_incomplete();
    load_table(1, 0, 0);
    checks++;
    if (tbl_ready !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL incomplete_ready: tbl_ready=%b err=%b, expected 1/0", tbl_ready, err);
    end
    run_stream(64'h7FFF, 15, 0, 0, 60);
    checks++;
    if (err !== 1'b0 || bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL incomplete_15: err=%b bit_ready=%b, expected 0/1", err, bit_ready);
    end
    run_stream(64'h1, 1, 0, 0, 20);
    checks++;
    if (err !== 1'b1 || bit_ready !== 1'b0 || sym_valid !== 1'b0) begin
      failures++;
      $display("FAIL incomplete_16: err=%b bit_ready=%b sym_valid=%b, expected 1/0/0", err, bit_ready, sym_valid);
    end
  endtask

  task automatic test_async_reset();
    load_table(1, 1, 2);
    run_stream(64'b11, 2, 0, 0, 20);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tbl_ready, bit_ready, sym_valid, sym_data, sym_len, err} !== 17'h0) begin
      failures++;
      $display("FAIL async_reset: got %b, expected all zero",
               {tbl_ready, bit_ready, sym_valid, sym_data, sym_len, err});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0; cfg_done = 1'b1;
    @(negedge clk); cfg_done = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (err !== 1'b1 || tbl_ready !== 1'b0) begin
      failures++;
      $display("FAIL empty_table: err=%b tbl_ready=%b, expected 1/0", err, tbl_ready);
    end
  endtask

  task automatic test_restart_mid_code();
    load_table(1, 1, 2);
    run_stream(64'b11, 2, 0, 0, 20);
    load_table(1, 1, 2);
    push(8'h41, 5'd1);
    run_stream(64'b0, 1, 0, 0, 20);
    repeat (4) @(negedge clk);
    checks++;
    if (sym_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL restart_extra: sym_valid=%b err=%b, expected 0/0", sym_valid, err);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cnt_we = 1'b0; cnt_len = 5'd0; cnt_val = 9'd0;
    sym_we = 1'b0; sym_addr = 8'd0; sym_val = 8'd0; cfg_done = 1'b0;
    bit_valid = 1'b0; bit_data = 1'b0; sym_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_random_stream();
    test_oversubscribed();
    test_incomplete();
    test_async_reset();
    test_restart_mid_code();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
